// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and the prescale-to-bit-period mapping,
// so transmitter and receiver agree on what one prescale unit means.
package uart_pkg;

  localparam int OVERSAMPLE = 8;
  localparam int TIMER_W    = 19;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  // Clocks per bit; a prescale of 0 behaves as 1 so the timer never stalls.
  function automatic logic [TIMER_W-1:0] bit_period(input logic [15:0] prescale);
    logic [15:0] eff;
    eff = (prescale == 16'd0) ? 16'd1 : prescale;
    return TIMER_W'(eff) * TIMER_W'(OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
// Latency 2 clk; no flow control.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver feeding a one-entry AXI-stream output register; tvalid rises the cycle
// after the stop-bit mid sample and is held until accepted, newer bytes overwrite (overrun).
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic rxd_s;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (rxd),
    .q_out (rxd_s)
  );

  rx_state_e             state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [TIMER_W-1:0]    reload_q, reload_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  busy_q, busy_d;
  logic                  frame_err_q, frame_err_d;
  logic                  byte_vld;
  logic                  timer_exp;
  logic [TIMER_W-1:0]    period;

  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  overrun_q, overrun_d;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    reload_d    = reload_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    busy_d      = busy_q;
    frame_err_d = 1'b0;
    byte_vld    = 1'b0;
    period      = bit_period(prescale);
    timer_exp   = (timer_q == '0);

    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d  = START;
          busy_d   = 1'b1;
          reload_d = period - TIMER_W'(1);
          timer_d  = (period >> 1) - TIMER_W'(1);
        end
      end
      START: begin
        if (timer_exp) begin
          if (!rxd_s) begin
            state_d   = DATA;
            timer_d   = reload_q;
            bit_cnt_d = '0;
          end else begin
            // Start bit did not survive to mid-bit: treat as line noise.
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      DATA: begin
        if (timer_exp) begin
          shift_d                 = shift_q >> 1;
          shift_d[DATA_WIDTH-1]   = rxd_s;
          timer_d                 = reload_q;
          bit_cnt_d               = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_d = STOP;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      STOP: begin
        if (timer_exp) begin
          if (rxd_s) begin
            byte_vld = 1'b1;
            state_d  = IDLE;
            busy_d   = 1'b0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      BREAK: begin
        // A line held low must return high before a new start can be seen.
        if (rxd_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      reload_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      reload_q    <= reload_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Output register: a handshake in the same cycle as a new byte frees the slot first.
  always_comb begin
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    overrun_d = 1'b0;
    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end
    if (byte_vld) begin
      tdata_d   = shift_q;
      tvalid_d  = 1'b1;
      overrun_d = tvalid_q && !m_axis_tready;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign overrun_error = overrun_q;
  assign frame_error   = frame_err_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis: frame-level model of when each byte lands in the
// output register, checked every cycle, plus literal per-scenario expectations.
module tb_uart_rx_axis;

  localparam int P   = 6;
  localparam int BIT = P * 8;
  // Edges from the rxd falling edge to the stop-bit sample: 2 sync + 1 detect,
  // half a bit to mid start, then 9 whole bits (8 data + stop).
  localparam int STOP_LAT = 3 + 4 * P + 9 * BIT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic        tready = 1'b0;
  logic [15:0] prescale = 16'(P);
  logic [7:0]  tdata;
  logic        tvalid, busy, overrun_error, frame_error;

  always #5 clk = ~clk;

  uart_rx_axis #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .rxd           (rxd),
    .busy          (busy),
    .overrun_error (overrun_error),
    .frame_error   (frame_error),
    .prescale      (prescale)
  );

  typedef struct {
    int         cyc;
    bit         good;
    logic [7:0] data;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] model_acc[$];
  logic [7:0] dut_acc[$];
  logic [7:0] sent[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         ov_cnt = 0;
  int         fe_cnt = 0;
  bit         rand_rdy = 1'b0;

  logic       m_vld = 1'b0;
  logic [7:0] m_dat = 8'h00;
  logic       m_ov = 1'b0;
  logic       m_fe = 1'b0;
  logic       prev_vld = 1'b0;
  logic [7:0] prev_dat = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Frame-level model: applies each scheduled frame outcome at its stop-sample edge.
  initial begin : compare
    ev_t e;
    bit  pending;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        m_vld = 1'b0;
        m_dat = 8'h00;
        m_ov  = 1'b0;
        m_fe  = 1'b0;
      end else begin
        m_ov = 1'b0;
        m_fe = 1'b0;
        if (prev_vld && tready) dut_acc.push_back(prev_dat);
        pending = m_vld && !tready;
        if (m_vld && tready) begin
          model_acc.push_back(m_dat);
          m_vld = 1'b0;
        end
        while (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
          e = ev_q.pop_front();
          if (e.good) begin
            m_ov  = pending;
            m_dat = e.data;
            m_vld = 1'b1;
          end else begin
            m_fe = 1'b1;
          end
        end
      end
      check("tvalid", 32'(tvalid), 32'(m_vld));
      check("tdata", 32'(tdata), 32'(m_dat));
      check("overrun_error", 32'(overrun_error), 32'(m_ov));
      check("frame_error", 32'(frame_error), 32'(m_fe));
      if (overrun_error === 1'b1) ov_cnt++;
      if (frame_error === 1'b1) fe_cnt++;
      prev_vld = tvalid;
      prev_dat = tdata;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input bit sched);
    logic [9:0] bits;
    ev_t        e;
    bits = {stop, b, 1'b0};
    @(negedge clk);
    if (sched) begin
      e.cyc  = cyc + STOP_LAT;
      e.good = stop;
      e.data = b;
      ev_q.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      for (int k = 0; k < BIT; k++) begin
        @(negedge clk);
        if (rand_rdy) tready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin : stim
    int base;
    logic [7:0] b;

    idle(3);
    check("reset_tvalid", 32'(tvalid), 32'd0);
    check("reset_tdata", 32'(tdata), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overrun", 32'(overrun_error), 32'd0);
    check("reset_frame_err", 32'(frame_error), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Single byte with consumer always ready
    tready = 1'b1;
    send_frame(8'h55, 1'b1, 1'b1);
    idle(BIT);
    check("t1_accepts", 32'(dut_acc.size()), 32'd1);
    check("t1_byte", 32'(dut_acc[0]), 32'h55);
    check("t1_model_byte", 32'(model_acc[0]), 32'h55);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_errors", 32'(ov_cnt + fe_cnt), 32'd0);

    // Two bytes while the consumer stalls: second overwrites the first
    tready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    idle(BIT);
    check("t2_tvalid_held", 32'(tvalid), 32'd1);
    check("t2_tdata", 32'(tdata), 32'h22);
    check("t2_overruns", 32'(ov_cnt), 32'd1);
    tready = 1'b1;
    idle(4);
    tready = 1'b0;
    check("t2_accepts", 32'(dut_acc.size()), 32'd2);
    check("t2_byte", 32'(dut_acc[1]), 32'h22);
    check("t2_tvalid_drop", 32'(tvalid), 32'd0);

    // Stop bit low, line held low (break), then recovery
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(2 * BIT);
    check("t3_busy_in_break", 32'(busy), 32'd1);
    rxd = 1'b1;
    idle(BIT);
    check("t3_frame_errs", 32'(fe_cnt), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_no_data", 32'(dut_acc.size()), 32'd2);
    tready = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(BIT);
    check("t3_accepts", 32'(dut_acc.size()), 32'd3);
    check("t3_byte", 32'(dut_acc[2]), 32'h3C);

    // Short low glitch is rejected at the mid-start check
    rxd = 1'b0;
    idle(10);
    rxd = 1'b1;
    check("t4_busy_during", 32'(busy), 32'd1);
    idle(20);
    check("t4_busy_after", 32'(busy), 32'd0);
    idle(BIT);
    check("t4_no_data", 32'(dut_acc.size()), 32'd3);
    check("t4_tvalid", 32'(tvalid), 32'd0);
    check("t4_frame_errs", 32'(fe_cnt), 32'd1);

    // Reset mid-frame (0xFF keeps the line high after the start bit)
    @(negedge clk);
    rxd = 1'b0;
    idle(BIT);
    rxd = 1'b1;
    idle(2 * BIT);
    check("t5_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("t5_tvalid", 32'(tvalid), 32'd0);
    check("t5_tdata", 32'(tdata), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    idle(8 * BIT);
    check("t5_no_data", 32'(dut_acc.size()), 32'd3);
    send_frame(8'h0F, 1'b1, 1'b1);
    idle(BIT);
    check("t5_accepts", 32'(dut_acc.size()), 32'd4);
    check("t5_byte", 32'(dut_acc[3]), 32'h0F);

    // Random bytes with a randomly stalling consumer
    base = dut_acc.size();
    rand_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      sent.push_back(b);
      send_frame(b, 1'b1, 1'b1);
    end
    rand_rdy = 1'b0;
    tready = 1'b1;
    for (int k = 0; k < 3000 && dut_acc.size() < base + 16; k++) @(negedge clk);
    check("t6_accepts", 32'(dut_acc.size()), 32'(base + 16));
    for (int i = 0; i < 16; i++) begin
      check("t6_byte", 32'(dut_acc[base + i]), 32'(sent[i]));
    end
    check("t6_overruns", 32'(ov_cnt), 32'd1);
    check("t6_frame_errs", 32'(fe_cnt), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
